// File: rtl/npu_pkg.sv
// npu_pkg
//   Types and defaults shared by the pixel front end (conv_window_gen,
//   conv_line_buf) and conv_unit.
//   - pixel_t      : unsigned 8-bit pixel
//   - CONV_K_H/K_W : default kernel height/width, shared with conv_unit
//   - win_state_e  : window generator frame state (FILL until K_H-1 rows are
//                    buffered, RUN while complete windows can be formed)
package npu_pkg;

   typedef logic [7:0] pixel_t;

   localparam int unsigned CONV_K_H = 3;
   localparam int unsigned CONV_K_W = 3;

   typedef enum logic {
      FILL = 1'b0,
      RUN  = 1'b1
   } win_state_e;

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf
//   One image row of pixel storage (DEPTH x 8), single address port.
//   Read-before-write: rd_data always shows the contents at addr as they were
//   before this cycle's write, so the caller gets the previous row's pixel at
//   the same column in the very cycle it stores the new one.
// Ports
//   clk      in   clock, rising edge
//   wr_en    in   write wr_data at addr on this edge
//   addr     in   column address (0..DEPTH-1)
//   wr_data  in   pixel to store
//   rd_data  out  current contents at addr
module conv_line_buf
   import npu_pkg::*;
#(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] addr,
   input  pixel_t        wr_data,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];

   // The old row pixel must be available in the accept cycle, so the read
   // port is asynchronous; the write lands on the clock edge, after the read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen
//   Raster-scan K_H x K_W window generator (stride 1, no padding) feeding
//   conv_unit. One pixel per handshake; K_H-1 cascaded line buffers hold the
//   previous rows. Every fully populated window is presented on conv_win with
//   win_valid, one cycle after the accept of its bottom-right pixel.
// Optional feature macro: CONV_WIN_STATS_EN adds the win_cnt output (windows
//   consumed this frame, saturating).
// Ports
//   clk, rst_n   clock / asynchronous active-low reset
//   pix_in       unsigned pixel
//   pix_sof      first pixel of a frame (meaningful on accept only)
//   pix_valid    pixel present
//   pix_ready    pixel accepted when pix_valid && pix_ready
//   conv_win     window, [0][0] = oldest row, leftmost column
//   win_valid    conv_win holds a new window
//   win_ready    consumer takes the window when win_valid && win_ready
//   frame_done   1-cycle pulse after the last pixel of a frame is accepted
//   win_cnt      windows consumed this frame (CONV_WIN_STATS_EN only)
module conv_window_gen
   import npu_pkg::*;
#(
   parameter int unsigned K_H   = CONV_K_H,
   parameter int unsigned K_W   = CONV_K_W,
   parameter int unsigned IMG_W = 32,
   parameter int unsigned IMG_H = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   input  pixel_t pix_in,
   input  logic   pix_sof,
   input  logic   pix_valid,
   output logic   pix_ready,
   output pixel_t conv_win [0:K_H-1][0:K_W-1],
   output logic   win_valid,
   input  logic   win_ready,
   output logic   frame_done
`ifdef CONV_WIN_STATS_EN
   ,
   output logic [15:0] win_cnt
`endif
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_WIN       = CW'(K_W - 1);
   localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_WIN       = RW'(K_H - 1);
   localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K_H - 2);

   win_state_e    state_reg;
   logic [CW-1:0] col_reg, col_next, pos_col;
   logic [RW-1:0] row_reg, row_next, pos_row;
   logic          accept;
   logic          win_done;
   logic          last_pix;
   logic          fill_last_pix;

   pixel_t lb_rd   [K_H-1];
   pixel_t lb_wr   [K_H-1];
   pixel_t col_vec [K_H];

   // A single output slot: a new pixel may enter only if the slot is empty or
   // is being emptied this cycle.
   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;

   // Position of the pixel on the input port; start-of-frame restarts at (0,0).
   assign pos_col = pix_sof ? '0 : col_reg;
   assign pos_row = pix_sof ? '0 : row_reg;

   assign win_done      = (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);
   assign last_pix      = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
   assign fill_last_pix = (pos_row == ROW_FILL_LAST) && (pos_col == COL_LAST);

   always_comb begin
      col_next = pos_col + 1'b1;
      row_next = pos_row;
      if (pos_col == COL_LAST) begin
         col_next = '0;
         row_next = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end
   end

   // Line-buffer cascade: buffer 0 stores the incoming row, buffer g stores
   // what buffer g-1 held, so buffer g reads back the row g+1 rows above.
   always_comb begin
      lb_wr[0] = pix_in;
      for (int j = 1; j < K_H - 1; j++) begin
         lb_wr[j] = lb_rd[j-1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < K_H - 1; gi++) begin : g_lb
         conv_line_buf #(
            .DEPTH (IMG_W)
         ) u_line_buf (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (pos_col),
            .wr_data (lb_wr[gi]),
            .rd_data (lb_rd[gi])
         );
      end
   endgenerate

   // New rightmost column: oldest row at index 0, incoming pixel at the bottom.
   always_comb begin
      col_vec[K_H-1] = pix_in;
      for (int j = 0; j < K_H - 1; j++) begin
         col_vec[K_H-2-j] = lb_rd[j];
      end
   end

   // The shift register is the output slot itself. While a window is pending
   // and unconsumed, pix_ready is low, no pixel is accepted and conv_win holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
               conv_win[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W - 1; c++) begin
               conv_win[r][c] <= conv_win[r][c+1];
            end
            conv_win[r][K_W-1] <= col_vec[r];
         end
      end
   end

   // Frame position, FSM and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= FILL;
         col_reg    <= '0;
         row_reg    <= '0;
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept && (state_reg == RUN) && last_pix;

         if (accept && win_done) begin
            win_valid <= 1'b1;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end

         if (accept) begin
            col_reg <= col_next;
            row_reg <= row_next;
            if (pix_sof) begin
               state_reg <= FILL;
            end else begin
               case (state_reg)
                  FILL:    if (fill_last_pix) state_reg <= RUN;
                  RUN:     if (last_pix)      state_reg <= FILL;
                  default:                    state_reg <= FILL;
               endcase
            end
         end
      end
   end

`ifdef CONV_WIN_STATS_EN
   // The final count is visible for one cycle after frame_done, then cleared.
   logic done_d_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt    <= '0;
         done_d_reg <= 1'b0;
      end else begin
         done_d_reg <= frame_done;
         if ((accept && pix_sof) || done_d_reg) begin
            win_cnt <= '0;
         end else if (win_valid && win_ready && (win_cnt != 16'hFFFF)) begin
            win_cnt <= win_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen
//   Directed bench for conv_window_gen with K_H=K_W=3, IMG_W=5, IMG_H=4.
//   Frame pixels are base+index (index 0..19, row-major). A window whose
//   top-left pixel has index tl holds base+tl+5*i+j at [i][j].
//   Define CONV_WIN_STATS_EN to also exercise win_cnt.
module tb_conv_window_gen;

   localparam int KH = 3;
   localparam int KW = 3;
   localparam int W  = 5;
   localparam int H  = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  pix_in;
   logic        pix_sof;
   logic        pix_valid;
   logic        pix_ready;
   logic [7:0]  conv_win [0:KH-1][0:KW-1];
   logic        win_valid;
   logic        win_ready;
   logic        frame_done;
`ifdef CONV_WIN_STATS_EN
   logic [15:0] win_cnt;
`endif

   conv_window_gen #(
      .K_H   (KH),
      .K_W   (KW),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_in     (pix_in),
      .pix_sof    (pix_sof),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .conv_win   (conv_win),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .frame_done (frame_done)
`ifdef CONV_WIN_STATS_EN
      ,
      .win_cnt    (win_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Vector table: top-left index, index of the pixel that completes the
   // window, and the expected window for a frame with base 0.
   typedef struct {
      int          tl;
      int          trig;
      logic [71:0] w;
   } vec_t;

   vec_t tbl [6];

   int n_vec;
   int n_bad;
   int rdy_mode;   // 0: win_ready=1, 1: random, 2: win_ready=0

   function automatic logic [71:0] flat_win();
      logic [71:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            r[(8-(i*3+j))*8 +: 8] = conv_win[i][j];
      return r;
   endfunction

   function automatic logic [71:0] golden(input int base, input int k);
      logic [71:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            r[(8-(i*3+j))*8 +: 8] = 8'(base + tbl[k].tl + i*W + j);
      return r;
   endfunction

   // win_ready driver, changes just after the rising edge.
   initial begin
      win_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       win_ready = 1'b1;
            1:       win_ready = 1'($urandom_range(1));
            default: win_ready = 1'b0;
         endcase
      end
   end

   // Monitor: records every consumed window and the accept count at that time.
   logic [71:0] got_q [$];
   int          lat_q [$];
   int          acc_cnt;
   int          fd_cnt;
`ifdef CONV_WIN_STATS_EN
   logic [15:0] cnt1_q [$];
   logic [15:0] cnt2_q [$];
   logic        fd_d1, fd_d2;
`endif

   initial begin
      acc_cnt = 0;
      fd_cnt  = 0;
`ifdef CONV_WIN_STATS_EN
      fd_d1 = 1'b0;
      fd_d2 = 1'b0;
`endif
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (win_valid && win_ready) begin
               got_q.push_back(flat_win());
               lat_q.push_back(acc_cnt);
            end
            if (pix_valid && pix_ready) acc_cnt++;
            if (frame_done) fd_cnt++;
         end
`ifdef CONV_WIN_STATS_EN
         if (fd_d1) cnt1_q.push_back(win_cnt);
         if (fd_d2) cnt2_q.push_back(win_cnt);
         fd_d2 = fd_d1;
         fd_d1 = frame_done && rst_n;
`endif
      end
   end

   task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end else begin
         $display("vec %0d %s: %0h ok", n_vec, name, got);
      end
   endtask

   task automatic send_pix(input logic [7:0] v, input logic s, input int gap);
      int t;
      while ($urandom_range(99) < gap) begin
         pix_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      pix_valid = 1'b1;
      pix_in    = v;
      pix_sof   = s;
      t = 0;
      forever begin
         @(negedge clk);
         if (pix_ready) break;
         t++;
         if (t > 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept timeout: pixel %0d not accepted, pix_ready %0b", v, pix_ready);
            break;
         end
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic send_frame(input int base, input logic sof, input int first, input int last, input int gap);
      for (int i = first; i <= last; i++)
         send_pix(8'(base + i), sof && (i == first), gap);
   endtask

   task automatic wait_win(input int b, input int n);
      int t;
      t = 0;
      while (got_q.size() < b + n && t < 300) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_wins(input string name, input int idx0, input int base, input int k0, input int n);
      for (int k = 0; k < n; k++) begin
         if (idx0 + k < got_q.size()) begin
            chk($sformatf("%s win%0d", name, k0 + k), got_q[idx0+k], golden(base, k0 + k));
         end else begin
            n_vec++;
            n_bad++;
            $display("FAIL %s win%0d: missing, expected %0h", name, k0 + k, golden(base, k0 + k));
         end
      end
   endtask

   initial begin
      int          b, a0, f0;
      logic [71:0] snap;
      logic        stall_bad;

      tbl[0] = '{tl: 0, trig: 12, w: {8'd0, 8'd1, 8'd2, 8'd5,  8'd6,  8'd7,  8'd10, 8'd11, 8'd12}};
      tbl[1] = '{tl: 1, trig: 13, w: {8'd1, 8'd2, 8'd3, 8'd6,  8'd7,  8'd8,  8'd11, 8'd12, 8'd13}};
      tbl[2] = '{tl: 2, trig: 14, w: {8'd2, 8'd3, 8'd4, 8'd7,  8'd8,  8'd9,  8'd12, 8'd13, 8'd14}};
      tbl[3] = '{tl: 5, trig: 17, w: {8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12, 8'd15, 8'd16, 8'd17}};
      tbl[4] = '{tl: 6, trig: 18, w: {8'd6, 8'd7, 8'd8, 8'd11, 8'd12, 8'd13, 8'd16, 8'd17, 8'd18}};
      tbl[5] = '{tl: 7, trig: 19, w: {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19}};

      n_vec     = 0;
      n_bad     = 0;
      rdy_mode  = 0;
      rst_n     = 1'b0;
      pix_in    = '0;
      pix_sof   = 1'b0;
      pix_valid = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst valid/done/ready", 72'({win_valid, frame_done, pix_ready}), 72'(3'b001));
      chk("rst conv_win", flat_win(), 72'd0);
`ifdef CONV_WIN_STATS_EN
      chk("rst win_cnt", 72'(win_cnt), 72'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: back-to-back frame, table-driven window and latency check
      b = got_q.size(); a0 = acc_cnt; f0 = fd_cnt;
      send_frame(0, 1'b1, 0, 19, 0);
      wait_win(b, 6);
      chk("t1 count", 72'(got_q.size() - b), 72'd6);
      for (int k = 0; k < 6; k++) begin
         if (b + k < got_q.size()) begin
            chk($sformatf("t1 win%0d", k), got_q[b+k], tbl[k].w);
            chk($sformatf("t1 lat%0d", k), 72'(lat_q[b+k] - a0), 72'(tbl[k].trig + 1));
         end
      end
      chk("t1 frame_done", 72'(fd_cnt - f0), 72'd1);

      // 2: consumer stalls on the first window for 10 cycles
      rdy_mode = 2;
      repeat (2) @(posedge clk);
      #1;
      b = got_q.size(); f0 = fd_cnt;
      send_frame(0, 1'b1, 0, 12, 0);
      @(negedge clk);
      snap = flat_win();
      chk("t2 first win", snap, tbl[0].w);
      chk("t2 valid/ready", 72'({win_valid, pix_ready}), 72'(2'b10));
      stall_bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (flat_win() !== snap || pix_ready !== 1'b0 || win_valid !== 1'b1) stall_bad = 1'b1;
      end
      chk("t2 frozen", 72'(stall_bad), 72'd0);
      rdy_mode = 0;
      send_frame(0, 1'b0, 13, 19, 0);
      wait_win(b, 6);
      chk("t2 count", 72'(got_q.size() - b), 72'd6);
      for (int k = 0; k < 6; k++)
         if (b + k < got_q.size()) chk($sformatf("t2 win%0d", k), got_q[b+k], tbl[k].w);
      chk("t2 frame_done", 72'(fd_cnt - f0), 72'd1);

      // 3: random gaps on both sides
      rdy_mode = 1;
      b = got_q.size(); f0 = fd_cnt;
      send_frame(50, 1'b1, 0, 19, 50);
      wait_win(b, 6);
      rdy_mode = 0;
      chk("t3 count", 72'(got_q.size() - b), 72'd6);
      check_wins("t3", b, 50, 0, 6);
      chk("t3 frame_done", 72'(fd_cnt - f0), 72'd1);

      // 4a: frame A aborted by sof on its pixel 8, then frame B
      b = got_q.size(); f0 = fd_cnt;
      send_frame(200, 1'b1, 0, 7, 0);
      send_frame(30, 1'b1, 0, 19, 0);
      wait_win(b, 6);
      chk("t4a count", 72'(got_q.size() - b), 72'd6);
      check_wins("t4a", b, 30, 0, 6);
      chk("t4a frame_done", 72'(fd_cnt - f0), 72'd1);

      // 4b: abort on pixel 16, after three windows of A
      b = got_q.size(); f0 = fd_cnt;
      send_frame(150, 1'b1, 0, 15, 0);
      send_frame(90, 1'b1, 0, 19, 0);
      wait_win(b, 9);
      chk("t4b count", 72'(got_q.size() - b), 72'd9);
      check_wins("t4b A", b, 150, 0, 3);
      check_wins("t4b B", b + 3, 90, 0, 6);
      chk("t4b frame_done", 72'(fd_cnt - f0), 72'd1);

      // 5: reset right after pixel 13, window from 13 pending and dropped
      b = got_q.size(); f0 = fd_cnt;
      send_frame(40, 1'b1, 0, 13, 0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t5 rst valid/done/ready", 72'({win_valid, frame_done, pix_ready}), 72'(3'b001));
      chk("t5 rst conv_win", flat_win(), 72'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t5 pre-reset count", 72'(got_q.size() - b), 72'd1);
      check_wins("t5 pre", b, 40, 0, 1);
      b = got_q.size();
      send_frame(70, 1'b0, 0, 19, 0);
      wait_win(b, 6);
      chk("t5 count", 72'(got_q.size() - b), 72'd6);
      check_wins("t5", b, 70, 0, 6);
      chk("t5 frame_done", 72'(fd_cnt - f0), 72'd1);

`ifdef CONV_WIN_STATS_EN
      // 6: window counter over two back-to-back frames
      begin
         int c1;
         c1 = cnt1_q.size();
         b  = got_q.size();
         send_frame(10, 1'b1, 0, 19, 0);
         send_frame(110, 1'b0, 0, 19, 0);
         wait_win(b, 12);
         check_wins("t6 f1", b, 10, 0, 6);
         check_wins("t6 f2", b + 6, 110, 0, 6);
         chk("t6 samples", 72'(cnt2_q.size() - c1), 72'd2);
         for (int f = 0; f < 2; f++) begin
            if (c1 + f < cnt2_q.size()) begin
               chk($sformatf("t6 f%0d win_cnt at done", f + 1), 72'(cnt1_q[c1+f]), 72'd6);
               chk($sformatf("t6 f%0d win_cnt cleared", f + 1), 72'(cnt2_q[c1+f]), 72'd0);
            end
         end
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
